segre_main_memory: RTL and testbench

- Line-granular main-memory responder on the core's memory port: addr/rd/wr/data_type/wr_data in, line read data and ready out.
- Serves instruction fetches and data-cache refills/write-backs with a fixed, parameterised access latency.
- Sits outside segre_core in the testbench/SoC top. It is the single slave the core's port multiplexer talks to.

---
 rtl/segre_main_memory.sv | 169 ++++++++++++++++
 tb/tb_segre_main_memory.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/segre_main_memory.sv
// segre_main_memory: line-granular main-memory responder for the core's memory port.
// A request is accepted in IDLE, held in BUSY for LATENCY cycles, and answered in a
// single RESP cycle with ready_o. Transfers are always one full cache line.
// Optional feature macro: SEGRE_MEM_RANGE_ERR_EN adds err_o. With it, addresses that
// have bits set above the line-index range are flagged, and they do not wrap.
// The storage array has no reset, so its contents survive rsn_i.

package segre_pkg;
  typedef enum logic [1:0] {
    MEMOP_BYTE = 2'd0,
    MEMOP_HALF = 2'd1,
    MEMOP_WORD = 2'd2
  } memop_data_type_e;
endpackage

module segre_main_memory
  import segre_pkg::*;
#(
  parameter int ADDR_SIZE             = 32,
  parameter int CACHE_LINE_SIZE_BYTES = 16,
  parameter int MEM_SIZE_LINES        = 4096,
  parameter int LATENCY               = 5
) (
  input  logic                               clk_i,
  input  logic                               rsn_i,
  input  logic [ADDR_SIZE-1:0]               addr_i,
  input  logic                               rd_i,
  input  logic                               wr_i,
  input  memop_data_type_e                   data_type_i,
  input  logic [CACHE_LINE_SIZE_BYTES*8-1:0] wr_data_i,
  output logic [CACHE_LINE_SIZE_BYTES*8-1:0] rd_data_o,
  output logic                               ready_o
`ifdef SEGRE_MEM_RANGE_ERR_EN
  ,
  output logic                               err_o
`endif
);

  localparam int         LINE_W   = CACHE_LINE_SIZE_BYTES * 8;
  localparam int         OFFSET_W = $clog2(CACHE_LINE_SIZE_BYTES);
  localparam int         IDX_W    = $clog2(MEM_SIZE_LINES);
  localparam logic [7:0] CNT_INIT = 8'(LATENCY - 1);

  if (LATENCY < 1 || LATENCY > 255) begin : g_bad_latency
    $fatal(1, "segre_main_memory: LATENCY must be in 1..255");
  end
  if ((CACHE_LINE_SIZE_BYTES & (CACHE_LINE_SIZE_BYTES - 1)) != 0) begin : g_bad_line
    $fatal(1, "segre_main_memory: CACHE_LINE_SIZE_BYTES must be a power of two");
  end
  if ((MEM_SIZE_LINES & (MEM_SIZE_LINES - 1)) != 0) begin : g_bad_size
    $fatal(1, "segre_main_memory: MEM_SIZE_LINES must be a power of two");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [7:0]          cnt_q, cnt_d;
  logic                accept;
  logic                resp_go;
  logic                mem_we;
  logic [IDX_W-1:0]    line_idx;
  logic [IDX_W-1:0]    req_idx_q;
  logic                req_wr_q;
  logic [LINE_W-1:0]   req_data_q;
  logic [LINE_W-1:0]   rd_line;
  logic [LINE_W-1:0]   mem [MEM_SIZE_LINES];

  // Access size and line offset do not affect a full-line transfer.
  logic unused_bits;
  assign unused_bits = ^{data_type_i, addr_i};

  // Taking only the index field drops the upper address bits, so addresses wrap.
  assign line_idx = addr_i[OFFSET_W +: IDX_W];
  assign resp_go  = (state_q == BUSY) && (cnt_q == 8'd0);

`ifdef SEGRE_MEM_RANGE_ERR_EN
  logic addr_oor;
  logic req_oor_q;
  assign addr_oor = (addr_i >> (OFFSET_W + IDX_W)) != '0;
  assign rd_line  = req_oor_q ? '0 : mem[req_idx_q];
  assign mem_we   = (state_q == RESP) && req_wr_q && !req_oor_q;
`else
  assign rd_line  = mem[req_idx_q];
  assign mem_we   = (state_q == RESP) && req_wr_q;
`endif

  // State and latency counter registers
  always_ff @(posedge clk_i or negedge rsn_i) begin
    if (!rsn_i) begin
      state_q <= IDLE;
      cnt_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic: accept in IDLE, count down in BUSY, answer for one cycle in RESP
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    accept  = 1'b0;
    case (state_q)
      IDLE: begin
        if (rd_i || wr_i) begin
          accept  = 1'b1;
          cnt_d   = CNT_INIT;
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (cnt_q == 8'd0) begin
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Request latch. A write takes priority when rd_i and wr_i are both set.
  always_ff @(posedge clk_i) begin
    if (accept) begin
      req_idx_q  <= line_idx;
      req_wr_q   <= wr_i;
      req_data_q <= wr_data_i;
`ifdef SEGRE_MEM_RANGE_ERR_EN
      req_oor_q  <= addr_oor;
`endif
    end
  end

  // Write commits at the end of RESP, so an aborted write never reaches the array.
  always_ff @(posedge clk_i) begin
    if (mem_we) begin
      mem[req_idx_q] <= req_data_q;
    end
  end

  // Response outputs launched on the BUSY->RESP edge. Read data holds between reads.
  always_ff @(posedge clk_i or negedge rsn_i) begin
    if (!rsn_i) begin
      ready_o   <= 1'b0;
      rd_data_o <= '0;
`ifdef SEGRE_MEM_RANGE_ERR_EN
      err_o     <= 1'b0;
`endif
    end else begin
      ready_o <= resp_go;
      if (resp_go && !req_wr_q) begin
        rd_data_o <= rd_line;
      end
`ifdef SEGRE_MEM_RANGE_ERR_EN
      err_o <= resp_go && req_oor_q;
`endif
    end
  end

endmodule

// File: tb/tb_segre_main_memory.sv
// Bench for segre_main_memory: directed scenarios followed by randomized line traffic,
// all checked against a line-array reference model held in the bench.
// Honours SEGRE_MEM_RANGE_ERR_EN in the same way as the design.
module tb_segre_main_memory;
  import segre_pkg::*;

  localparam int L       = 5;
  localparam int LINES   = 4096;
  localparam int LBYTES  = 16;
  localparam int IDX_LSB = 4;   // log2(LBYTES)
  localparam int TOP_LSB = 16;  // log2(LBYTES) + log2(LINES)

  logic             clk = 1'b0;
  logic             rsn = 1'b1;
  logic [31:0]      addr = '0;
  logic             rd = 1'b0;
  logic             wr = 1'b0;
  memop_data_type_e data_type = MEMOP_WORD;
  logic [127:0]     wr_data = '0;
  logic [127:0]     rd_data;
  logic             ready;
  logic             err;

  segre_main_memory #(
    .ADDR_SIZE            (32),
    .CACHE_LINE_SIZE_BYTES(LBYTES),
    .MEM_SIZE_LINES       (LINES),
    .LATENCY              (L)
  ) dut (
    .clk_i      (clk),
    .rsn_i      (rsn),
    .addr_i     (addr),
    .rd_i       (rd),
    .wr_i       (wr),
    .data_type_i(data_type),
    .wr_data_i  (wr_data),
    .rd_data_o  (rd_data),
    .ready_o    (ready)
`ifdef SEGRE_MEM_RANGE_ERR_EN
    ,
    .err_o      (err)
`endif
  );

`ifndef SEGRE_MEM_RANGE_ERR_EN
  assign err = 1'b0;
`endif

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Reference model: plain line array plus the value rd_data_o should be holding.
  logic [127:0] model_mem [LINES];
  bit           model_vld [LINES];
  logic [127:0] exp_rd = '0;
  bit           exp_rd_known = 1'b0;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  function automatic logic [127:0] fill(input logic [7:0] b);
    return {16{b}};
  endfunction

  function automatic int line_of(input logic [31:0] a);
    return int'((a >> IDX_LSB) % LINES);
  endfunction

  function automatic bit out_of_range(input logic [31:0] a);
`ifdef SEGRE_MEM_RANGE_ERR_EN
    return (a >> TOP_LSB) != 0;
`else
    return 1'b0;
`endif
  endfunction

  // Issue one request, wait for its response, and check it against the model.
  task automatic do_req(input logic r, input logic w, input logic [31:0] a,
                        input logic [127:0] d, input string tag);
    int n;
    bit seen;
    int idx;
    bit oor;
    @(negedge clk);
    rd = r; wr = w; addr = a; wr_data = d;
    data_type = memop_data_type_e'($urandom_range(0, 2));
    @(posedge clk);
    #1;
    rd = 1'b0; wr = 1'b0;
    wr_data = {$urandom, $urandom, $urandom, $urandom};
    addr = $urandom;
    n = 0;
    seen = 1'b0;
    while (!seen && n < 300) begin
      @(negedge clk);
      n++;
      if (ready === 1'b1) seen = 1'b1;
    end
    chk({tag, "_latency"}, 128'(n), 128'(L + 1));
    idx = line_of(a);
    oor = out_of_range(a);
    chk({tag, "_err"}, 128'(err), 128'(oor));
    if (w) begin
      if (exp_rd_known) chk({tag, "_rd_hold"}, rd_data, exp_rd);
      if (!oor) begin
        model_mem[idx] = d;
        model_vld[idx] = 1'b1;
      end
    end else begin
      if (oor) begin
        exp_rd = '0;
        exp_rd_known = 1'b1;
      end else begin
        exp_rd = model_mem[idx];
        exp_rd_known = model_vld[idx];
      end
      if (exp_rd_known) chk({tag, "_rd_data"}, rd_data, exp_rd);
    end
    @(negedge clk);
    chk({tag, "_pulse_width"}, 128'(ready), 128'(0));
  endtask

  // Hold reset low for a few cycles in IDLE and check the outputs stay cleared.
  task automatic pulse_reset(input int cycles);
    @(negedge clk);
    rsn = 1'b0;
    #1;
    for (int i = 0; i < cycles; i++) begin
      chk("rst_ready", 128'(ready), 128'(0));
      chk("rst_rd_data", rd_data, '0);
      chk("rst_err", 128'(err), 128'(0));
      @(negedge clk);
    end
    rsn = 1'b1;
    exp_rd = '0;
    exp_rd_known = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n_pulses;
    int stray;
    logic [31:0] a;
    logic r, w;

    // Power-on reset
    #2;
    pulse_reset(3);

    // Basic write then read of the same line through a different offset
    do_req(1'b0, 1'b1, 32'h0000_0100, fill(8'hA5), "basic_wr");
    do_req(1'b1, 1'b0, 32'h0000_010C, '0, "basic_rd");
    chk("basic_value", rd_data, fill(8'hA5));

    // Storage survives a reset taken while idle
    do_req(1'b0, 1'b1, 32'h0000_0030, fill(8'h11), "persist_wr");
    pulse_reset(3);
    do_req(1'b1, 1'b0, 32'h0000_0030, '0, "persist_rd");

    // Reset in the middle of a write discards it
    do_req(1'b0, 1'b1, 32'h0000_0040, fill(8'h66), "abort_prior_wr");
    @(negedge clk);
    wr = 1'b1; addr = 32'h0000_0040; wr_data = fill(8'h22);
    @(posedge clk);
    #1;
    wr = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rsn = 1'b0;
    #1;
    chk("abort_ready", 128'(ready), 128'(0));
    chk("abort_rd_data", rd_data, '0);
    @(negedge clk);
    @(negedge clk);
    rsn = 1'b1;
    exp_rd = '0;
    exp_rd_known = 1'b1;
    repeat (L + 3) begin
      @(negedge clk);
      chk("abort_no_resp", 128'(ready), 128'(0));
    end
    do_req(1'b1, 1'b0, 32'h0000_0040, '0, "abort_rd");
    chk("abort_value", rd_data, fill(8'h66));

    // rd and wr together behave as a write
    do_req(1'b1, 1'b1, 32'h0000_0080, fill(8'h33), "both_wr");
    do_req(1'b1, 1'b0, 32'h0000_0080, '0, "both_rd");
    chk("both_value", rd_data, fill(8'h33));

    // Upper address bits: wrap in the default build, flagged with the range check
    do_req(1'b0, 1'b1, 32'h0000_0000, fill(8'h55), "wrap_prior_wr");
    do_req(1'b0, 1'b1, 32'h0001_0000, fill(8'h44), "wrap_wr");
    do_req(1'b1, 1'b0, 32'h0000_0000, '0, "wrap_rd");

    // Held read request: a new response every L+2 cycles
    @(negedge clk);
    rd = 1'b1; wr = 1'b0; addr = 32'h0000_0104;
    n_pulses = 0;
    for (int n = 1; n <= 3 * (L + 2) + (L + 1); n++) begin
      @(negedge clk);
      chk("held_ready", 128'(ready), 128'((n % (L + 2)) == (L + 1)));
      if (ready === 1'b1) begin
        n_pulses++;
        chk("held_rd_data", rd_data, fill(8'hA5));
      end
    end
    rd = 1'b0;
    chk("held_pulses", 128'(n_pulses), 128'(4));
    stray = 0;
    repeat (L + 4) begin
      @(negedge clk);
      if (ready !== 1'b0) stray++;
    end
    chk("held_release", 128'(stray), 128'(0));
    exp_rd = fill(8'hA5);
    exp_rd_known = 1'b1;

    // Randomized traffic over a small set of lines, some with upper address bits set
    for (int k = 0; k < 40; k++) begin
      a = (32'($urandom_range(0, 15)) << IDX_LSB) | 32'($urandom_range(0, 15));
      if ($urandom_range(0, 3) == 0) a = a | (32'($urandom_range(1, 7)) << TOP_LSB);
      r = 1'($urandom_range(0, 1));
      w = 1'($urandom_range(0, 1));
      if (!r && !w) r = 1'b1;
      do_req(r, w, a, {$urandom, $urandom, $urandom, $urandom}, "rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
